// File: rtl/writeback_if.sv
// Writeback interface: ALU result handshake, load result path, and the
// register-file write port with occupancy/retire counters.
//
// Handshake: an ALU result transfers on a rising clk edge where
// alu_valid && alu_ready. alu_ready is driven only from registered state.
// The load path has no ready; the writeback unit must take it every cycle.
interface writeback_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              reg_write;
  logic [4:0]        reg_wr_addr_wb;
  logic [DATA_W-1:0] reg_wr_data;
  logic [2:0]        pending_count;
  logic [31:0]       retired_count;

  // Upstream side: offers results, observes the write port
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, reg_write, reg_wr_addr_wb, reg_wr_data,
           pending_count, retired_count
  );

  // Writeback unit side
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, reg_write, reg_wr_addr_wb, reg_wr_data,
           pending_count, retired_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates load and ALU results onto the single register
// file write port. Loads always win; ALU results that lose are queued in an
// in-order FIFO and drained ahead of new ALU results. rd==0 is never written.
module writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       reset,
  writeback_if.slave wb
);
  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(DEPTH);

  logic [4:0]        fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [2:0]        count;

  logic              accept;
  logic              mem_win;
  logic              fifo_ne;
  logic              pop;
  logic              push;
  logic              bypass;
  logic              win_valid;
  logic [4:0]        win_rd;
  logic [DATA_W-1:0] win_data;

  // Ready comes from occupancy alone; a pop in the same cycle gives no credit
  assign wb.alu_ready     = (count != FULL);
  assign wb.pending_count = count;

  assign accept  = wb.alu_valid && wb.alu_ready;
  assign mem_win = wb.mem_valid && (wb.mem_rd != 5'd0);
  assign fifo_ne = (count != 3'd0);

  // Priority: load, then FIFO head, then direct ALU bypass when FIFO is empty
  always_comb begin
    pop       = 1'b0;
    bypass    = 1'b0;
    win_valid = 1'b0;
    win_rd    = 5'd0;
    win_data  = '0;
    if (mem_win) begin
      win_valid = 1'b1;
      win_rd    = wb.mem_rd;
      win_data  = wb.mem_data;
    end else if (fifo_ne) begin
      pop       = 1'b1;
      win_valid = 1'b1;
      win_rd    = fifo_rd[head];
      win_data  = fifo_data[head];
    end else if (accept && (wb.alu_rd != 5'd0)) begin
      bypass    = 1'b1;
      win_valid = 1'b1;
      win_rd    = wb.alu_rd;
      win_data  = wb.alu_data;
    end
  end

  // Accepted ALU results for a real register that did not bypass go to the tail
  assign push = accept && (wb.alu_rd != 5'd0) && !bypass;

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= wb.alu_rd;
      fifo_data[tail] <= wb.alu_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
    end else begin
      if (pop)  head <= head + AW'(1);
      if (push) tail <= tail + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Registered write port; address/data hold between writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb.reg_write      <= 1'b0;
      wb.reg_wr_addr_wb <= 5'd0;
      wb.reg_wr_data    <= '0;
      wb.retired_count  <= 32'd0;
    end else begin
      wb.reg_write <= win_valid;
      if (win_valid) begin
        wb.reg_wr_addr_wb <= win_rd;
        wb.reg_wr_data    <= win_data;
        wb.retired_count  <= wb.retired_count + 32'd1;
      end
    end
  end
endmodule
